px_roi_decimate: RTL and testbench

- Pixel-stream conditioning stage between the stonyman readout sequencer and the four fifo_px write ports.
- Tracks row/column position of every 4-channel pixel beat, passes only beats inside a programmable region of interest (ROI), and applies power-of-two row/column decimation.
- Drives fifo_px WE/DATA so the APB3 side reads only the useful pixels.
- Counts beats dropped on FIFO-full and flags frame completion.

---
 rtl/px_pkg.sv | 35 +++
 rtl/px_roi_pos_counter.sv | 70 +++++++
 rtl/px_roi_decimate.sv | 183 ++++++++++++++++++
 tb/tb_px_roi_decimate.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/px_pkg.sv
// Shared definitions for the pixel ROI/decimation stage.
//   - Default frame geometry and sample width (stonyman 112x112, 8-bit samples).
//   - cfg_dec step codes and dec_mask(), which maps a step code to (step - 1).
//   - Frame sequencing state enum.
package px_pkg;

  localparam int unsigned ImgWDefault = 112;
  localparam int unsigned ImgHDefault = 112;
  localparam int unsigned PxWDefault  = 8;
  localparam int unsigned CwDefault   = 7;

  // cfg_dec codes: decimation step applied to both rows and columns.
  localparam logic [1:0] DecStep1 = 2'd0;
  localparam logic [1:0] DecStep2 = 2'd1;
  localparam logic [1:0] DecStep4 = 2'd2;
  localparam logic [1:0] DecStep8 = 2'd3;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } px_state_e;

  // Returns (step - 1); an offset is on the decimation grid when (offset & mask) == 0.
  function automatic logic [2:0] dec_mask(input logic [1:0] dec);
    logic [2:0] mask;
    case (dec)
      DecStep1: mask = 3'b000;
      DecStep2: mask = 3'b001;
      DecStep4: mask = 3'b011;
      default:  mask = 3'b111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/px_roi_pos_counter.sv
// Row/column position tracker for the pixel beat stream.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   clear                 frame start: current beat (if any) is treated as position (0,0)
//   advance               a beat is consumed this cycle; position moves on afterwards
//   col_start..row_end    effective inclusive ROI bounds for this beat
//   dec                   effective decimation step code
//   match                 current position lies in the ROI and on the decimation grid
//   last                  current position is the final pixel of the frame
module px_roi_pos_counter
  import px_pkg::*;
#(
  parameter int unsigned IMG_W = ImgWDefault,
  parameter int unsigned IMG_H = ImgHDefault,
  parameter int unsigned CW    = CwDefault
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  input  logic [CW-1:0] col_start,
  input  logic [CW-1:0] col_end,
  input  logic [CW-1:0] row_start,
  input  logic [CW-1:0] row_end,
  input  logic [1:0]    dec,
  output logic          match,
  output logic          last
);

  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [CW-1:0] RowLast = CW'(IMG_H - 1);

  logic [CW-1:0] col_q, row_q;
  logic [CW-1:0] cur_col, cur_row;
  logic [CW-1:0] col_off, row_off, mask;
  logic          in_bounds;

  always_comb begin
    // A frame start restarts the position immediately, so a coincident beat is (0,0).
    cur_col   = clear ? '0 : col_q;
    cur_row   = clear ? '0 : row_q;
    last      = (cur_row == RowLast) && (cur_col == ColLast);
    mask      = CW'(dec_mask(dec));
    in_bounds = (cur_row >= row_start) && (cur_row <= row_end) &&
                (cur_col >= col_start) && (cur_col <= col_end);
    // Offsets wrap when out of bounds, but in_bounds masks those cases.
    col_off   = cur_col - col_start;
    row_off   = cur_row - row_start;
    match     = in_bounds && ((col_off & mask) == '0) && ((row_off & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (advance) begin
      if (cur_col == ColLast) begin
        col_q <= '0;
        row_q <= (cur_row == RowLast) ? '0 : cur_row + 1'b1;
      end else begin
        col_q <= cur_col + 1'b1;
        row_q <= cur_row;
      end
    end else if (clear) begin
      col_q <= '0;
      row_q <= '0;
    end
  end

endmodule

// File: rtl/px_roi_decimate.sv
// Pixel-stream conditioning between the stonyman readout sequencer and the fifo_px
// write ports: ROI window, power-of-two decimation, drop counting and frame tracking.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   frame_start                 capture start pulse; latches cfg_* and (re)starts a frame
//   in_valid, px0_in..px3_in    pixel beat strobe and the four camera samples
//   fifo_full                   OR of the fifo_px FULL flags
//   cfg_col/row_start/end       inclusive ROI bounds; cfg_dec decimation step code
//   out_valid, px0_out..px3_out FIFO write enable and registered samples
//   frame_done                  one-cycle pulse after the last beat of a frame
//   drop_count                  passing beats lost to fifo_full this frame (saturating)
//   busy                        high while a frame is in progress
//   stat_min/max/sum            camera-0 statistics over written samples, only when
//                               PX_ROI_STATS_EN is defined
module px_roi_decimate
  import px_pkg::*;
#(
  parameter int unsigned IMG_W = ImgWDefault,
  parameter int unsigned IMG_H = ImgHDefault,
  parameter int unsigned PX_W  = PxWDefault,
  parameter int unsigned CW    = CwDefault
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            frame_start,
  input  logic            in_valid,
  input  logic [PX_W-1:0] px0_in,
  input  logic [PX_W-1:0] px1_in,
  input  logic [PX_W-1:0] px2_in,
  input  logic [PX_W-1:0] px3_in,
  input  logic            fifo_full,
  input  logic [CW-1:0]   cfg_col_start,
  input  logic [CW-1:0]   cfg_col_end,
  input  logic [CW-1:0]   cfg_row_start,
  input  logic [CW-1:0]   cfg_row_end,
  input  logic [1:0]      cfg_dec,
  output logic            out_valid,
  output logic [PX_W-1:0] px0_out,
  output logic [PX_W-1:0] px1_out,
  output logic [PX_W-1:0] px2_out,
  output logic [PX_W-1:0] px3_out,
  output logic            frame_done,
  output logic [15:0]     drop_count,
  output logic            busy
`ifdef PX_ROI_STATS_EN
  ,
  output logic [PX_W-1:0]    stat_min,
  output logic [PX_W-1:0]    stat_max,
  output logic [PX_W+13:0]   stat_sum
`endif
);

  px_state_e       state_q;
  logic [CW-1:0]   col_start_q, col_end_q, row_start_q, row_end_q;
  logic [1:0]      dec_q;
  logic [CW-1:0]   col_start_e, col_end_e, row_start_e, row_end_e;
  logic [1:0]      dec_e;
  logic            out_valid_q, frame_done_q, busy_q;
  logic [PX_W-1:0] px0_q, px1_q, px2_q, px3_q;
  logic [15:0]     drop_q;
  logic            beat, match, last, write, drop;

  always_comb begin
    // On frame_start the coincident beat must already see the new configuration.
    col_start_e = frame_start ? cfg_col_start : col_start_q;
    col_end_e   = frame_start ? cfg_col_end   : col_end_q;
    row_start_e = frame_start ? cfg_row_start : row_start_q;
    row_end_e   = frame_start ? cfg_row_end   : row_end_q;
    dec_e       = frame_start ? cfg_dec       : dec_q;
    beat        = in_valid && ((state_q == StRun) || frame_start);
    write       = beat && match && !fifo_full;
    drop        = beat && match && fifo_full;
  end

  px_roi_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CW    (CW)
  ) u_pos (
    .clk       (clk),
    .reset     (reset),
    .clear     (frame_start),
    .advance   (beat),
    .col_start (col_start_e),
    .col_end   (col_end_e),
    .row_start (row_start_e),
    .row_end   (row_end_e),
    .dec       (dec_e),
    .match     (match),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      out_valid_q  <= 1'b0;
      px0_q        <= '0;
      px1_q        <= '0;
      px2_q        <= '0;
      px3_q        <= '0;
      drop_q       <= '0;
      col_start_q  <= '0;
      col_end_q    <= '0;
      row_start_q  <= '0;
      row_end_q    <= '0;
      dec_q        <= '0;
    end else begin
      out_valid_q  <= write;
      frame_done_q <= 1'b0;
      if (write) begin
        px0_q <= px0_in;
        px1_q <= px1_in;
        px2_q <= px2_in;
        px3_q <= px3_in;
      end
      if (frame_start) begin
        // Start or abort-and-restart; an aborted frame never reports frame_done.
        col_start_q <= cfg_col_start;
        col_end_q   <= cfg_col_end;
        row_start_q <= cfg_row_start;
        row_end_q   <= cfg_row_end;
        dec_q       <= cfg_dec;
        state_q     <= StRun;
        busy_q      <= 1'b1;
        drop_q      <= drop ? 16'd1 : 16'd0;
      end else begin
        if (drop && (drop_q != 16'hFFFF)) begin
          drop_q <= drop_q + 16'd1;
        end
        case (state_q)
          StRun: begin
            if (beat && last) begin
              state_q      <= StIdle;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign px0_out    = px0_q;
  assign px1_out    = px1_q;
  assign px2_out    = px2_q;
  assign px3_out    = px3_q;
  assign frame_done = frame_done_q;
  assign drop_count = drop_q;
  assign busy       = busy_q;

`ifdef PX_ROI_STATS_EN
  logic [PX_W-1:0]  stat_min_q, stat_max_q;
  logic [PX_W+13:0] stat_sum_q;

  // Folds in the sample on the FIFO port, so results trail out_valid by one cycle.
  // No writes occur outside a frame, which keeps the values frozen after frame_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_min_q <= '0;
      stat_max_q <= '0;
      stat_sum_q <= '0;
    end else if (frame_start) begin
      stat_min_q <= '1;
      stat_max_q <= '0;
      stat_sum_q <= '0;
    end else if (out_valid_q) begin
      if (px0_q < stat_min_q) stat_min_q <= px0_q;
      if (px0_q > stat_max_q) stat_max_q <= px0_q;
      stat_sum_q <= stat_sum_q + (PX_W+14)'(px0_q);
    end
  end

  assign stat_min = stat_min_q;
  assign stat_max = stat_max_q;
  assign stat_sum = stat_sum_q;
`endif

endmodule

// File: tb/tb_px_roi_decimate.sv
// Self-checking bench for px_roi_decimate: randomized pixel beats checked against a
// frame-index reference model (row = idx / W, col = idx % W, modulo-step decimation).
module tb_px_roi_decimate;

  localparam int W = 112;
  localparam int H = 112;

  logic        clk = 1'b0;
  logic        reset, frame_start, in_valid, fifo_full;
  logic [7:0]  px0_in, px1_in, px2_in, px3_in;
  logic [6:0]  cfg_col_start, cfg_col_end, cfg_row_start, cfg_row_end;
  logic [1:0]  cfg_dec;
  logic        out_valid, frame_done, busy;
  logic [7:0]  px0_out, px1_out, px2_out, px3_out;
  logic [15:0] drop_count;
`ifdef PX_ROI_STATS_EN
  logic [7:0]  stat_min, stat_max;
  logic [21:0] stat_sum;
`endif

  px_roi_decimate dut (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (frame_start),
    .in_valid      (in_valid),
    .px0_in        (px0_in),
    .px1_in        (px1_in),
    .px2_in        (px2_in),
    .px3_in        (px3_in),
    .fifo_full     (fifo_full),
    .cfg_col_start (cfg_col_start),
    .cfg_col_end   (cfg_col_end),
    .cfg_row_start (cfg_row_start),
    .cfg_row_end   (cfg_row_end),
    .cfg_dec       (cfg_dec),
    .out_valid     (out_valid),
    .px0_out       (px0_out),
    .px1_out       (px1_out),
    .px2_out       (px2_out),
    .px3_out       (px3_out),
    .frame_done    (frame_done),
    .drop_count    (drop_count),
    .busy          (busy)
`ifdef PX_ROI_STATS_EN
    ,
    .stat_min      (stat_min),
    .stat_max      (stat_max),
    .stat_sum      (stat_sum)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  // Observation capture only; comparisons live in the test tasks.
  logic [31:0] got_q[$];
  int          done_cyc[$];
  bit          done_busy[$];
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) got_q.push_back({px3_out, px2_out, px1_out, px0_out});
      if (frame_done) begin
        done_cyc.push_back(cyc_cnt);
        done_busy.push_back(busy);
      end
    end
  end

  // Reference model state.
  logic [31:0] exp_q[$];
  int m_cs, m_ce, m_rs, m_re, m_step;
  int m_idx = 0;
  int m_drop = 0;
  bit m_run = 0;
  int last_beat_cyc = -1;
  bit ramp_mode = 0;
  int ramp_cnt = 0;

  function automatic bit m_pass(input int r, input int c);
    return (r >= m_rs) && (r <= m_re) && (c >= m_cs) && (c <= m_ce) &&
           ((c - m_cs) % m_step == 0) && ((r - m_rs) % m_step == 0);
  endfunction

  function automatic int count_diff();
    int n = 0;
    if (got_q.size() != exp_q.size()) return -1;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      px0_in = 8'($urandom);
      step();
    end
  endtask

  task automatic set_cfg(input int cs, input int ce, input int rs, input int re, input int dec);
    cfg_col_start = 7'(cs);
    cfg_col_end   = 7'(ce);
    cfg_row_start = 7'(rs);
    cfg_row_end   = 7'(re);
    cfg_dec       = 2'(dec);
  endtask

  task automatic model_start();
    m_cs = int'(cfg_col_start);
    m_ce = int'(cfg_col_end);
    m_rs = int'(cfg_row_start);
    m_re = int'(cfg_row_end);
    m_step = 1 << int'(cfg_dec);
    m_idx = 0;
    m_drop = 0;
    m_run = 1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    done_cyc.delete();
    done_busy.delete();
  endtask

  // Drives one beat and advances the model.
  task automatic beat(input bit fs, input bit full);
    bit p;
    if (fs) model_start();
    p = m_run && m_pass(m_idx / W, m_idx % W);
    px0_in = 8'($urandom);
    px1_in = 8'($urandom);
    px2_in = 8'($urandom);
    px3_in = 8'($urandom);
    if (ramp_mode && p) begin
      px0_in = 8'(ramp_cnt % 256);
      ramp_cnt++;
    end
    if (p) begin
      if (full) begin
        if (m_drop < 65535) m_drop++;
      end else begin
        exp_q.push_back({px3_in, px2_in, px1_in, px0_in});
      end
    end
    frame_start = fs;
    in_valid    = 1'b1;
    fifo_full   = full;
    step();
    frame_start = 1'b0;
    in_valid    = 1'b0;
    fifo_full   = 1'b0;
    if (m_run) begin
      if (m_idx == W * H - 1) begin
        m_run = 0;
        m_idx = 0;
        last_beat_cyc = cyc_cnt;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic fs_only();
    model_start();
    frame_start = 1'b1;
    in_valid    = 1'b0;
    step();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    frame_start = 1'b0;
    in_valid = 1'b0;
    fifo_full = 1'b0;
    px0_in = 8'hA5; px1_in = 8'h5A; px2_in = 8'h3C; px3_in = 8'hC3;
    set_cfg(0, 111, 0, 111, 0);
    repeat (3) step();
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid got=%b need=0", out_valid); end
    checks++; if ({px3_out, px2_out, px1_out, px0_out} !== 32'h0) begin errors++;
      $display("FAIL reset_px got=%h need=0", {px3_out, px2_out, px1_out, px0_out}); end
    checks++; if (frame_done !== 1'b0) begin errors++;
      $display("FAIL reset_frame_done got=%b need=0", frame_done); end
    checks++; if (drop_count !== 16'd0) begin errors++;
      $display("FAIL reset_drop got=%0d need=0", drop_count); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy got=%b need=0", busy); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_full_frame();
    int nd;
    set_cfg(0, 111, 0, 111, 0);
    clear_obs();
    beat(1, 0);
    for (int i = 1; i < W * H; i++) begin
      beat(0, 0);
      if (i == 100) begin
        checks++; if (busy !== 1'b1) begin errors++;
          $display("FAIL full_busy_mid got=%b need=1", busy); end
      end
    end
    idle(3);
    checks++; if (got_q.size() !== W * H) begin errors++;
      $display("FAIL full_count got=%0d need=%0d", got_q.size(), W * H); end
    nd = count_diff();
    checks++; if (nd !== 0) begin errors++;
      $display("FAIL full_data got=%0d bad need=0", nd); end
    checks++; if (done_cyc.size() !== 1) begin errors++;
      $display("FAIL full_done_count got=%0d need=1", done_cyc.size()); end
    if (done_cyc.size() >= 1) begin
      checks++; if (done_cyc[0] !== last_beat_cyc) begin errors++;
        $display("FAIL full_done_time got=%0d need=%0d", done_cyc[0], last_beat_cyc); end
      checks++; if (done_busy[0] !== 1'b0) begin errors++;
        $display("FAIL full_done_busy got=%b need=0", done_busy[0]); end
    end
    checks++; if (drop_count !== 16'd0) begin errors++;
      $display("FAIL full_drop got=%0d need=0", drop_count); end
  endtask

  task automatic test_roi_dec();
    int nd;
    set_cfg(10, 19, 5, 6, 1);
    clear_obs();
    beat(1, 0);
    for (int i = 1; i < 8 * W; i++) begin
      if (i == 300) set_cfg(0, 111, 0, 111, 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      beat(0, 0);
    end
    idle(2);
    checks++; if (got_q.size() !== 5) begin errors++;
      $display("FAIL roi_count got=%0d need=5", got_q.size()); end
    nd = count_diff();
    checks++; if (nd !== 0) begin errors++;
      $display("FAIL roi_data got=%0d bad need=0", nd); end
  endtask

  task automatic test_abort();
    int nd;
    set_cfg(20, 30, 20, 30, 0);
    clear_obs();
    beat(1, 0);
    for (int i = 1; i < 500; i++) beat(0, 0);
    idle(2);
    checks++; if (got_q.size() !== 0) begin errors++;
      $display("FAIL abort_old_writes got=%0d need=0", got_q.size()); end
    set_cfg(0, 3, 0, 0, 0);
    beat(1, 0);
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL abort_busy got=%b need=1", busy); end
    for (int i = 1; i < W * H; i++) beat(0, 0);
    idle(3);
    checks++; if (got_q.size() !== 4) begin errors++;
      $display("FAIL abort_count got=%0d need=4", got_q.size()); end
    nd = count_diff();
    checks++; if (nd !== 0) begin errors++;
      $display("FAIL abort_data got=%0d bad need=0", nd); end
    checks++; if (done_cyc.size() !== 1) begin errors++;
      $display("FAIL abort_done_count got=%0d need=1", done_cyc.size()); end
  endtask

  task automatic test_backpressure();
    int nd;
    set_cfg(0, 9, 0, 1, 0);
    clear_obs();
    beat(1, 0);
    for (int i = 1; i < 30; i++) beat(0, (i == 2) || (i == 5) || (i == 7) || (i == 15));
    idle(2);
    checks++; if (drop_count !== 16'd3) begin errors++;
      $display("FAIL bp_drop got=%0d need=3", drop_count); end
    checks++; if (got_q.size() !== 7) begin errors++;
      $display("FAIL bp_count got=%0d need=7", got_q.size()); end
    nd = count_diff();
    checks++; if (nd !== 0) begin errors++;
      $display("FAIL bp_data got=%0d bad need=0", nd); end
    fs_only();
    checks++; if (drop_count !== 16'd0) begin errors++;
      $display("FAIL bp_drop_clear got=%0d need=0", drop_count); end
  endtask

  task automatic test_degenerate();
    set_cfg(50, 40, 0, 111, 0);
    clear_obs();
    beat(1, 0);
    for (int i = 1; i < W * H; i++) begin
      if (i == 3000) set_cfg(0, 111, 0, 111, 0);
      beat(0, 0);
    end
    idle(3);
    checks++; if (got_q.size() !== 0) begin errors++;
      $display("FAIL degen_writes got=%0d need=0", got_q.size()); end
    checks++; if (done_cyc.size() !== 1) begin errors++;
      $display("FAIL degen_done_count got=%0d need=1", done_cyc.size()); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL degen_busy got=%b need=0", busy); end
  endtask

  task automatic test_idle_ignored();
    clear_obs();
    for (int i = 0; i < 10; i++) beat(0, 0);
    idle(2);
    checks++; if (got_q.size() !== 0) begin errors++;
      $display("FAIL idle_writes got=%0d need=0", got_q.size()); end
    checks++; if (busy !== 1'b0 || done_cyc.size() !== 0) begin errors++;
      $display("FAIL idle_state got busy=%b done=%0d need busy=0 done=0",
               busy, done_cyc.size()); end
  endtask

  task automatic test_random();
    int cs, ce, rs, re, nd;
    for (int r = 0; r < 3; r++) begin
      cs = $urandom_range(0, 111);
      ce = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 111) : $urandom_range(cs, 111);
      rs = $urandom_range(0, 4);
      re = $urandom_range(rs, 7);
      set_cfg(cs, ce, rs, re, $urandom_range(0, 3));
      clear_obs();
      beat(1, $urandom_range(0, 4) == 0);
      for (int i = 1; i < 8 * W; i++) begin
        if ($urandom_range(0, 4) == 0) idle(1);
        if (i == 200) set_cfg($urandom_range(0, 111), 111, 0, 111, $urandom_range(0, 3));
        beat(0, $urandom_range(0, 4) == 0);
      end
      idle(2);
      nd = count_diff();
      checks++; if (nd !== 0) begin errors++;
        $display("FAIL rand%0d_data got=%0d bad (n=%0d) need=0 (n=%0d)",
                 r, nd, got_q.size(), exp_q.size()); end
      checks++; if (int'(drop_count) !== m_drop) begin errors++;
        $display("FAIL rand%0d_drop got=%0d need=%0d", r, drop_count, m_drop); end
    end
  endtask

  task automatic test_reset_run();
    set_cfg(0, 111, 0, 111, 0);
    clear_obs();
    beat(1, 0);
    for (int i = 1; i < 20; i++) beat(0, i == 3);
    checks++; if (drop_count !== 16'd1) begin errors++;
      $display("FAIL rst_run_drop_pre got=%0d need=1", drop_count); end
    reset = 1'b1;
    in_valid = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL rst_run_ctl got ov=%b busy=%b need 0 0", out_valid, busy); end
    checks++; if ({px3_out, px2_out, px1_out, px0_out} !== 32'h0 || drop_count !== 16'd0)
    begin errors++;
      $display("FAIL rst_run_data got px=%h drop=%0d need 0 0",
               {px3_out, px2_out, px1_out, px0_out}, drop_count); end
    reset = 1'b0;
    in_valid = 1'b0;
    m_run = 0;
    m_idx = 0;
    step();
  endtask

`ifdef PX_ROI_STATS_EN
  task automatic test_stats();
    int sum;
    set_cfg(0, 111, 0, 2, 0);
    clear_obs();
    fs_only();
    checks++; if (stat_min !== 8'hFF || stat_max !== 8'h00 || stat_sum !== 22'd0) begin
      errors++;
      $display("FAIL stats_init got min=%0d max=%0d sum=%0d need 255 0 0",
               stat_min, stat_max, stat_sum); end
    ramp_mode = 1;
    ramp_cnt = 0;
    for (int i = 0; i < W * H; i++) beat(0, 0);
    ramp_mode = 0;
    idle(4);
    sum = 0;
    foreach (exp_q[i]) sum += int'(exp_q[i][7:0]);
    checks++; if (stat_min !== 8'd0 || stat_max !== 8'd255) begin errors++;
      $display("FAIL stats_minmax got min=%0d max=%0d need 0 255", stat_min, stat_max); end
    checks++; if (int'(stat_sum) !== sum) begin errors++;
      $display("FAIL stats_sum got=%0d need=%0d", stat_sum, sum); end
  endtask
`endif

  initial begin
    #990000;
    $display("FAIL watchdog got=timeout need=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_roi_dec();
    test_abort();
    test_backpressure();
    test_degenerate();
    test_idle_ignored();
    test_random();
    test_reset_run();
`ifdef PX_ROI_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
